// File: rtl/instruction_loader.sv
`default_nettype none
// ============================================================================
// Module   : instruction_loader
// Purpose  : Boot-time instruction memory writer. Receives a byte stream
//            (header N, then 4*N bytes MSB first) over a valid/ready
//            handshake, assembles big-endian words, writes them to
//            consecutive word-aligned addresses and holds the CPU in reset
//            until the complete image has been written.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_loader #(
    parameter int DATA_WIDTH       = 32,
    parameter int NUM_INSTRUCTIONS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_Start,
    input  logic                  i_Byte_Valid,
    input  logic [7:0]            i_Byte,
    output logic                  o_Byte_Ready,
    output logic                  o_Write_Enable,
    output logic [DATA_WIDTH-1:0] o_Write_Address,
    output logic [DATA_WIDTH-1:0] o_Write_Data,
    output logic                  o_Busy,
    output logic                  o_Done,
    output logic                  o_Error,
    output logic                  o_CPU_Reset
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HEADER  = 3'd1;
    localparam logic [2:0] S_COLLECT = 3'd2;
    localparam logic [2:0] S_WRITE   = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam logic [2:0] S_ERROR   = 3'd5;

    localparam logic [DATA_WIDTH-1:0] c_ADDR_STEP = DATA_WIDTH'(4);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]            r_state;
    logic [7:0]            r_n;          // latched image length in words
    logic [1:0]            r_byte_idx;   // position of next byte in word
    logic [7:0]            r_word_cnt;   // words already written
    logic [DATA_WIDTH-1:0] r_addr;       // byte address of current word
    logic [DATA_WIDTH-1:0] r_buffer;     // word assembly shift register
    logic [DATA_WIDTH-1:0] r_wr_addr;    // address presented to memory
    logic [DATA_WIDTH-1:0] r_wr_data;    // data presented to memory

    // ------------------------------------------------------------------
    // Combinational wires
    // ------------------------------------------------------------------
    logic [2:0] w_next_state;
    logic       w_ready;
    logic       w_xfer;
    logic       w_hdr_bad;
    logic       w_last_word;
    logic       w_last_byte;

    // Ready depends only on registered state, so the handshake has no
    // combinational input-to-output path.
    assign w_ready     = (r_state == S_HEADER) || (r_state == S_COLLECT);
    assign w_xfer      = i_Byte_Valid && w_ready;
    assign w_hdr_bad   = (i_Byte == 8'd0) || (int'(i_Byte) > NUM_INSTRUCTIONS);
    assign w_last_byte = (r_byte_idx == 2'd3);
    assign w_last_word = ((r_word_cnt + 8'd1) == r_n);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_Start) begin
                    w_next_state = S_HEADER;
                end
            end
            S_HEADER: begin
                if (w_xfer) begin
                    w_next_state = w_hdr_bad ? S_ERROR : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (w_xfer && w_last_byte) begin
                    w_next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                w_next_state = w_last_word ? S_DONE : S_COLLECT;
            end
            S_DONE: begin
                if (i_Start) begin
                    w_next_state = S_HEADER;
                end
            end
            S_ERROR: begin
                if (i_Start) begin
                    w_next_state = S_HEADER;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Moore output decode from the registered state
    always_comb begin
        o_Byte_Ready   = 1'b0;
        o_Write_Enable = 1'b0;
        o_Busy         = 1'b0;
        o_Done         = 1'b0;
        o_Error        = 1'b0;
        o_CPU_Reset    = 1'b1;
        case (r_state)
            S_HEADER: begin
                o_Byte_Ready = 1'b1;
                o_Busy       = 1'b1;
            end
            S_COLLECT: begin
                o_Byte_Ready = 1'b1;
                o_Busy       = 1'b1;
            end
            S_WRITE: begin
                o_Write_Enable = 1'b1;
                o_Busy         = 1'b1;
            end
            S_DONE: begin
                o_Done      = 1'b1;
                o_CPU_Reset = 1'b0;
            end
            S_ERROR: begin
                o_Error = 1'b1;
            end
            default: begin
                o_Byte_Ready = 1'b0;
            end
        endcase
    end

    // Datapath: header latch, byte assembly, word/address bookkeeping.
    // The write address/data pair is captured on the 4th byte so that it
    // is stable during WRITE and holds afterwards, even when a new header
    // clears the working address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_n        <= 8'd0;
            r_byte_idx <= 2'd0;
            r_word_cnt <= 8'd0;
            r_addr     <= '0;
            r_buffer   <= '0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            case (r_state)
                S_HEADER: begin
                    if (w_xfer && !w_hdr_bad) begin
                        r_n        <= i_Byte;
                        r_byte_idx <= 2'd0;
                        r_word_cnt <= 8'd0;
                        r_addr     <= '0;
                        r_buffer   <= '0;
                    end
                end
                S_COLLECT: begin
                    if (w_xfer) begin
                        r_buffer   <= {r_buffer[DATA_WIDTH-9:0], i_Byte};
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (w_last_byte) begin
                            r_wr_addr <= r_addr;
                            r_wr_data <= {r_buffer[DATA_WIDTH-9:0], i_Byte};
                        end
                    end
                end
                S_WRITE: begin
                    r_word_cnt <= r_word_cnt + 8'd1;
                    if (!w_last_word) begin
                        r_addr <= r_addr + c_ADDR_STEP;
                    end
                end
                default: begin
                    r_n <= r_n;
                end
            endcase
        end
    end

    assign o_Write_Address = r_wr_addr;
    assign o_Write_Data    = r_wr_data;

endmodule
`default_nettype wire
